// File: rtl/strng_ctrl.sv
// Sequences strng_core: held in reset until en, warm-up discard, repetition health test, then packs samples into words.
// Word latency WORDS sample cycles + 1; a presented word is held in HOLD with no sampling until out_ready is seen.
module strng_ctrl #(
    parameter int STR_LEN    = 8,
    parameter int OUT_W      = 32,
    parameter int WARMUP_CYC = 256,
    parameter int REP_LIMIT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               core_rstn,
    input  logic [STR_LEN-1:0] rnd_data,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               fail
);
    localparam int WORDS = OUT_W / STR_LEN;
    localparam int SW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WW    = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int RW    = $clog2(REP_LIMIT + 1);

    localparam logic [SW-1:0] SMP_LAST  = SW'(WORDS - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_HOLD,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [WW-1:0]      warm_cnt_q, warm_cnt_d;
    logic [SW-1:0]      smp_cnt_q, smp_cnt_d;
    logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
    logic [STR_LEN-1:0] prev_q, prev_d;
    logic [OUT_W-1:0]   shreg_q, shreg_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               core_rstn_q, core_rstn_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               fail_q, fail_d;
    logic [OUT_W-1:0]   shifted;
    logic [RW-1:0]      rep_next;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        prev_d     = prev_q;
        shreg_d    = shreg_q;
        out_data_d = out_data_q;
        shifted    = (shreg_q << STR_LEN) | OUT_W'(rnd_data);
        rep_next   = RW'(1);

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d    = S_WARMUP;
                    warm_cnt_d = '0;
                end
            end
            S_WARMUP: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (warm_cnt_q == WARM_LAST) begin
                    state_d   = S_COLLECT;
                    smp_cnt_d = '0;
                    // zero run length marks "no previous sample" for the health test
                    rep_cnt_d = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + WW'(1);
                end
            end
            S_COLLECT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    if ((rep_cnt_q != '0) && (rnd_data == prev_q)) begin
                        rep_next = rep_cnt_q + RW'(1);
                    end
                    rep_cnt_d = rep_next;
                    prev_d    = rnd_data;
                    shreg_d   = shifted;
                    if (rep_next == REP_MAX) begin
                        state_d = S_FAIL;
                    end else if (smp_cnt_q == SMP_LAST) begin
                        state_d    = S_HOLD;
                        out_data_d = shifted;
                        smp_cnt_d  = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + SW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    state_d = S_COLLECT;
                end
            end
            default: ;
        endcase

        busy_d      = (state_d == S_WARMUP) || (state_d == S_COLLECT) || (state_d == S_HOLD);
        core_rstn_d = busy_d;
        out_valid_d = (state_d == S_HOLD);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            warm_cnt_q  <= '0;
            smp_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            prev_q      <= '0;
            shreg_q     <= '0;
            out_data_q  <= '0;
            core_rstn_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            prev_q      <= prev_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            core_rstn_q <= core_rstn_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
        end
    end

    assign core_rstn = core_rstn_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_strng_ctrl.sv
// Self-checking bench for strng_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_strng_ctrl;
    localparam int WARMUP = 4;
    localparam int REP    = 4;
    localparam int WORDS  = 4;

    localparam int MD_IDLE = 0;
    localparam int MD_WARM = 1;
    localparam int MD_COLL = 2;
    localparam int MD_HOLD = 3;
    localparam int MD_FAIL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        core_rstn;
    logic [7:0]  rnd_data = 8'h00;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        fail;

    int errors = 0;
    int checks = 0;

    strng_ctrl #(
        .STR_LEN   (8),
        .OUT_W     (32),
        .WARMUP_CYC(WARMUP),
        .REP_LIMIT (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .core_rstn(core_rstn),
        .rnd_data (rnd_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode, warm-up cycles left, collected samples, current run length.
    int          m_mode = MD_IDLE;
    int          m_warm_left = 0;
    int          m_run = 0;
    logic [7:0]  m_last = 8'h00;
    logic [7:0]  m_q[$];
    logic [31:0] m_word = 32'h0;

    task automatic model_step(input logic r, input logic e, input logic [7:0] d, input logic rdy);
        if (r) begin
            m_mode = MD_IDLE;
            m_q.delete();
            m_run  = 0;
            m_word = 32'h0;
        end else begin
            case (m_mode)
                MD_IDLE: if (e) begin
                    m_mode      = MD_WARM;
                    m_warm_left = WARMUP;
                end
                MD_WARM: if (!e) m_mode = MD_IDLE;
                else begin
                    m_warm_left--;
                    if (m_warm_left == 0) begin
                        m_mode = MD_COLL;
                        m_run  = 0;
                    end
                end
                MD_COLL: if (!e) begin
                    m_mode = MD_IDLE;
                    m_q.delete();
                end else begin
                    m_run  = (m_run > 0 && d == m_last) ? m_run + 1 : 1;
                    m_last = d;
                    m_q.push_back(d);
                    if (m_run >= REP) begin
                        m_mode = MD_FAIL;
                        m_q.delete();
                    end else if (m_q.size() == WORDS) begin
                        m_word = 32'h0;
                        foreach (m_q[i]) m_word = (m_word << 8) | 32'(m_q[i]);
                        m_q.delete();
                        m_mode = MD_HOLD;
                    end
                end
                MD_HOLD: if (!e) m_mode = MD_IDLE;
                else if (rdy) m_mode = MD_COLL;
                default: ;
            endcase
        end
    endtask

    // One clock: apply inputs, advance the model, sample DUT 1 time unit after the edge.
    task automatic cyc(input logic r, input logic e, input logic [7:0] d, input logic rdy);
        rst       = r;
        en        = e;
        rnd_data  = d;
        out_ready = rdy;
        model_step(r, e, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        checks++; if (core_rstn !== 1'b0) begin errors++; $display("FAIL reset_core_rstn got=%b exp=0", core_rstn); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", fail); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_first_word();
        cyc(1'b0, 1'b1, 8'h5A, 1'b0);
        checks++; if (core_rstn !== 1'b1) begin errors++; $display("FAIL warm_core_rstn got=%b exp=1", core_rstn); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL warm_busy got=%b exp=1", busy); end
        // identical warm-up samples must not feed the health test
        for (int i = 0; i < WARMUP; i++) cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        checks++; if (out_valid !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL warm_end valid=%b fail=%b exp=0/0", out_valid, fail); end
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL word1_early_valid got=%b exp=0", out_valid); end
        cyc(1'b0, 1'b1, 8'h44, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL word1_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h11223344) begin errors++; $display("FAIL word1_data got=%h exp=11223344", out_data); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h11223344) begin
                errors++; $display("FAIL hold_stable cyc=%0d valid=%b data=%h exp=1/11223344", i, out_valid, out_data);
            end
        end
        cyc(1'b0, 1'b1, 8'h99, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_accept_valid got=%b exp=0", out_valid); end
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        cyc(1'b0, 1'b1, 8'h66, 1'b0);
        cyc(1'b0, 1'b1, 8'h77, 1'b0);
        cyc(1'b0, 1'b1, 8'h88, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55667788) begin errors++; $display("FAIL word2 valid=%b data=%h exp=1/55667788", out_valid, out_data); end
        cyc(1'b0, 1'b1, 8'h88, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL word2_accept_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_fail();
        for (int i = 0; i < REP - 1; i++) cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rep3_fail got=%b exp=0", fail); end
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL rep4_fail got=%b exp=1", fail); end
        checks++; if (core_rstn !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rep4_outputs core_rstn=%b busy=%b valid=%b exp=0/0/0", core_rstn, busy, out_valid);
        end
        checks++; if (out_data !== 32'h55667788) begin errors++; $display("FAIL rep4_data_kept got=%h exp=55667788", out_data); end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        checks++; if (fail !== 1'b1 || core_rstn !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fail_sticky fail=%b core_rstn=%b busy=%b exp=1/0/0", fail, core_rstn, busy);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL fail_clear got=%b exp=0", fail); end
    endtask

    task automatic test_runs();
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < WARMUP; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        checks++; if (fail !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA5A5A53C) begin
            errors++; $display("FAIL runs_word1 fail=%b valid=%b data=%h exp=0/1/a5a5a53c", fail, out_valid, out_data);
        end
        cyc(1'b0, 1'b1, 8'hA5, 1'b1);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'h7E, 1'b0);
        checks++; if (fail !== 1'b0 || out_data !== 32'hA5A5A57E) begin
            errors++; $display("FAIL runs_word2 fail=%b data=%h exp=0/a5a5a57e", fail, out_data);
        end
        // a run that straddles HOLD still counts
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        checks++; if (out_data !== 32'h112233A5) begin errors++; $display("FAIL runs_word3 got=%h exp=112233a5", out_data); end
        cyc(1'b0, 1'b1, 8'hA5, 1'b1);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL runs_hold_3 got=%b exp=0", fail); end
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL runs_hold_4 got=%b exp=1", fail); end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_disable();
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < WARMUP; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'hDE, 1'b0);
        cyc(1'b0, 1'b1, 8'hAD, 1'b0);
        cyc(1'b0, 1'b0, 8'h01, 1'b0);
        checks++; if (busy !== 1'b0 || core_rstn !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL dis_idle busy=%b core_rstn=%b valid=%b exp=0/0/0", busy, core_rstn, out_valid);
        end
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'hBE, 1'b0);
        cyc(1'b0, 1'b1, 8'hEF, 1'b0);
        cyc(1'b0, 1'b1, 8'hBE, 1'b0);
        cyc(1'b0, 1'b1, 8'hEF, 1'b0);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dis_rewarm valid=%b busy=%b exp=0/1", out_valid, busy); end
        cyc(1'b0, 1'b1, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 8'h02, 1'b0);
        cyc(1'b0, 1'b1, 8'h03, 1'b0);
        cyc(1'b0, 1'b1, 8'h04, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h01020304) begin
            errors++; $display("FAIL dis_word valid=%b data=%h exp=1/01020304", out_valid, out_data);
        end
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 8'h05, 1'b0);
        cyc(1'b0, 1'b1, 8'h06, 1'b0);
        cyc(1'b0, 1'b1, 8'h07, 1'b0);
        cyc(1'b0, 1'b0, 8'h08, 1'b0);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h01020304) begin
            errors++; $display("FAIL dis_vs_complete valid=%b busy=%b data=%h exp=0/0/01020304", out_valid, busy, out_data);
        end
    endtask

    task automatic test_random();
        logic       r, e, rdy;
        logic [7:0] d;
        logic       exp_busy;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            e   = ($urandom_range(0, 49) != 0);
            rdy = ($urandom_range(0, 1) == 1);
            d   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
            cyc(r, e, d, rdy);
            exp_busy = (m_mode == MD_WARM) || (m_mode == MD_COLL) || (m_mode == MD_HOLD);
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy); end
            checks++; if (core_rstn !== exp_busy) begin errors++; $display("FAIL rnd_core_rstn cyc=%0d got=%b exp=%b", i, core_rstn, exp_busy); end
            checks++; if (out_valid !== (m_mode == MD_HOLD)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, m_mode == MD_HOLD); end
            checks++; if (fail !== (m_mode == MD_FAIL)) begin errors++; $display("FAIL rnd_fail cyc=%0d got=%b exp=%b", i, fail, m_mode == MD_FAIL); end
            checks++; if (out_data !== m_word) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, m_word); end
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_hold();
        test_fail();
        test_runs();
        test_disable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
